// File: rtl/sobel_edge_stream_pkg.sv
// Shared definitions for the Sobel edge stream.
// Purpose: pixel/word/gradient widths and the RGB-to-gray conversion used by the top.
// Ports: none (package).
package sobel_edge_stream_pkg;

    localparam int unsigned PixelSize = 24;  // R=[7:0], G=[15:8], B=[23:16]
    localparam int unsigned WordSize  = 8;   // one gray sample
    localparam int unsigned GradSize  = 11;  // |dx|+|dy|, max 2040

    // Shift-add luma approximation; every term is 8 bits and the sum peaks at 234,
    // so the 8-bit result never wraps.
    function automatic logic [WordSize-1:0] rgb_to_gray(input logic [PixelSize-1:0] px);
        logic [WordSize-1:0] r;
        logic [WordSize-1:0] g;
        logic [WordSize-1:0] b;
        r = px[7:0];
        g = px[15:8];
        b = px[23:16];
        return (r >> 2) + (r >> 5) + (g >> 1) + (g >> 4) + (b >> 4) + (b >> 5);
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel magnitude.
// Purpose: computes |dx|+|dy| over a 3x3 window of 8-bit gray samples.
// Ports:
//   win_i  9 samples, win_i[8*k +: 8] = p(k+1); p1..p3 top row, p7..p9 bottom row,
//          p1/p4/p7 left column.
//   mag_o  11-bit unsigned gradient magnitude.
module sobel_kernel
    import sobel_edge_stream_pkg::*;
(
    input  logic [9*WordSize-1:0] win_i,
    output logic [GradSize-1:0]   mag_o
);

    logic signed [11:0] p [9];
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic [GradSize-1:0] adx;
    logic [GradSize-1:0] ady;

    // The centre sample does not contribute to either gradient.
    logic unused_centre;
    assign unused_centre = ^win_i[4*WordSize +: WordSize];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            p[k] = {4'b0000, win_i[k*WordSize +: WordSize]};
        end
        dx  = (p[0] + (p[3] <<< 1) + p[6]) - (p[2] + (p[5] <<< 1) + p[8]);
        dy  = (p[0] + (p[1] <<< 1) + p[2]) - (p[6] + (p[7] <<< 1) + p[8]);
        // |dx|,|dy| <= 1020, so the 11-bit truncation is lossless.
        adx = dx[11] ? GradSize'(-dx) : GradSize'(dx);
        ady = dy[11] ? GradSize'(-dy) : GradSize'(dy);
        mag_o = adx + ady;
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming Sobel edge detector.
// Purpose: one RGB pixel in per valid cycle, one edge pixel out exactly 3 cycles later.
//   S1 registers gray/position/controls, S2 reads+writes the line buffers and shifts the
//   3x3 window, S3 runs the kernel, border mask and output mode.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   in_valid/in_sof  input strobe and start-of-frame (sof qualified by valid)
//   in_data          RGB pixel
//   threshold, mode  binary threshold / 0=binary 1=magnitude, sampled per pixel
//   out_valid/out_sof/out_data  delayed stream, edge value on all three channels
//   frame_err        pulse with the output of a pixel whose sof arrived mid-frame
module sobel_edge_stream
    import sobel_edge_stream_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [PixelSize-1:0] in_data,
    input  logic [GradSize-1:0]  threshold,
    input  logic                 mode,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [PixelSize-1:0] out_data,
    output logic                 frame_err
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);

    // Position counters (position of the next accepted pixel).
    logic [XW-1:0] x_q, x_d, pix_x;
    logic [YW-1:0] y_q, y_d, pix_y;
    logic          pix_err;

    // S1
    logic                v1_q, v1_d;
    logic [WordSize-1:0] gray1_q, gray1_d;
    logic [XW-1:0]       x1_q, x1_d;
    logic [YW-1:0]       y1_q, y1_d;
    logic                sof1_q, sof1_d, err1_q, err1_d, mode1_q, mode1_d;
    logic [GradSize-1:0] thr1_q, thr1_d;

    // S2
    logic                     v2_q, v2_d;
    logic [8:0][WordSize-1:0] win_q, win_d;
    logic [XW-1:0]            x2_q, x2_d;
    logic [YW-1:0]            y2_q, y2_d;
    logic                     sof2_q, sof2_d, err2_q, err2_d, mode2_q, mode2_d;
    logic [GradSize-1:0]      thr2_q, thr2_d;

    // S3
    logic                 out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic                 frame_err_q, frame_err_d;
    logic [PixelSize-1:0] out_data_q, out_data_d;

    // lb0 holds row y-1, lb1 holds row y-2, both indexed by x. Not reset: rows 0-1
    // are masked, so stale contents can never reach the output.
    logic [WordSize-1:0] lb0_mem [WIDTH];
    logic [WordSize-1:0] lb1_mem [WIDTH];
    logic [WordSize-1:0] row0_rd, row1_rd;

    logic [GradSize-1:0] mag, mag_masked;
    logic [WordSize-1:0] chan;

    // Position tracking: sof forces (0,0) and flags a frame error if we were mid-frame.
    always_comb begin
        pix_x   = x_q;
        pix_y   = y_q;
        pix_err = 1'b0;
        if (in_sof) begin
            pix_x   = '0;
            pix_y   = '0;
            pix_err = (x_q != '0) || (y_q != '0);
        end
        x_d = x_q;
        y_d = y_q;
        if (in_valid) begin
            if (pix_x == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = (pix_y == YW'(HEIGHT - 1)) ? '0 : pix_y + 1'b1;
            end else begin
                x_d = pix_x + 1'b1;
                y_d = pix_y;
            end
        end
    end

    always_comb begin
        v1_d    = in_valid;
        gray1_d = gray1_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        sof1_d  = sof1_q;
        err1_d  = err1_q;
        thr1_d  = thr1_q;
        mode1_d = mode1_q;
        if (in_valid) begin
            gray1_d = rgb_to_gray(in_data);
            x1_d    = pix_x;
            y1_d    = pix_y;
            sof1_d  = in_sof;
            err1_d  = pix_err;
            thr1_d  = threshold;
            mode1_d = mode;
        end
    end

    assign row0_rd = lb0_mem[x1_q];
    assign row1_rd = lb1_mem[x1_q];

    // Window rows top->bottom are y-2, y-1, y; the new column enters on the right.
    always_comb begin
        v2_d    = v1_q;
        win_d   = win_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        sof2_d  = sof2_q;
        err2_d  = err2_q;
        thr2_d  = thr2_q;
        mode2_d = mode2_q;
        if (v1_q) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = row1_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = row0_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = gray1_q;
            x2_d     = x1_q;
            y2_d     = y1_q;
            sof2_d   = sof1_q;
            err2_d   = err1_q;
            thr2_d   = thr1_q;
            mode2_d  = mode1_q;
        end
    end

    sobel_kernel u_kernel (
        .win_i (win_q),
        .mag_o (mag)
    );

    always_comb begin
        mag_masked = ((x2_q < XW'(2)) || (y2_q < YW'(2))) ? '0 : mag;
        if (mode2_q) begin
            chan = (mag_masked > GradSize'(255)) ? 8'hFF : mag_masked[7:0];
        end else begin
            chan = (mag_masked > thr2_q) ? 8'hFF : 8'h00;
        end
        out_valid_d = v2_q;
        out_sof_d   = v2_q & sof2_q;
        frame_err_d = v2_q & err2_q;
        out_data_d  = v2_q ? {chan, chan, chan} : '0;
    end

    always_ff @(posedge clk) begin
        if (v1_q) begin
            lb0_mem[x1_q] <= gray1_q;
            lb1_mem[x1_q] <= row0_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            v1_q        <= 1'b0;
            gray1_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            sof1_q      <= 1'b0;
            err1_q      <= 1'b0;
            thr1_q      <= '0;
            mode1_q     <= 1'b0;
            v2_q        <= 1'b0;
            win_q       <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            sof2_q      <= 1'b0;
            err2_q      <= 1'b0;
            thr2_q      <= '0;
            mode2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            frame_err_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            v1_q        <= v1_d;
            gray1_q     <= gray1_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            sof1_q      <= sof1_d;
            err1_q      <= err1_d;
            thr1_q      <= thr1_d;
            mode1_q     <= mode1_d;
            v2_q        <= v2_d;
            win_q       <= win_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
            sof2_q      <= sof2_d;
            err2_q      <= err2_d;
            thr2_q      <= thr2_d;
            mode2_q     <= mode2_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            frame_err_q <= frame_err_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign frame_err = frame_err_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/sobel_edge_stream.md
# sobel_edge_stream

Streaming Sobel edge detector, parametrised successor to the fixed single-threshold edge stage: accepts one RGB pixel per valid cycle, converts to grayscale, holds two line buffers of WIDTH entries plus a 3x3 window, and emits one edge pixel per accepted pixel at fixed latency. Adds a valid/start-of-frame stream, frame-position tracking with border masking, full-precision gradient arithmetic, a runtime threshold and a binary/magnitude output mode. It sits between the video input stage and the downstream labelling logic.

## Interface
- WIDTH, 640, pixels per line (>= 4)
- HEIGHT, 480, lines per frame (>= 3)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_data/in_sof valid this cycle; no backpressure
- in_sof  in  1  qualified by in_valid; first pixel of a frame
- in_data  in  `PIXEL_SIZE (24)  R=[7:0], G=[15:8], B=[23:16]
- threshold  in  11  edge threshold, sampled with each accepted pixel
- mode  in  1  0 = binary, 1 = magnitude; sampled with each accepted pixel
- out_valid  out  1  one pulse per accepted input pixel
- out_sof  out  1  in_sof delayed with its pixel
- out_data  out  `PIXEL_SIZE  edge value replicated on all 3 channels
- frame_err  out  1  one-cycle pulse on malformed frame

## Operation
- Grayscale: I = (R>>2)+(R>>5)+(G>>1)+(G>>4)+(B>>4)+(B>>5), 8-bit, no overflow possible (max 234).
- Position counters x (0..WIDTH-1), y (0..HEIGHT-1) advance per accepted pixel only; x wraps to 0 and increments y; after (WIDTH-1, HEIGHT-1) both wrap to 0 (implicit new frame).
- in_sof with in_valid forces that pixel to (0,0). If counters were not at (0,0) at that moment, frame_err pulses.
- Line buffers: two WIDTH x 8 memories indexed by x; read old rows at x, write new I. 3x3 window shifts one column per accepted pixel only; idle cycles freeze all state.
- Window for input pixel (x,y) is centred at (x-1,y-1). dx = (p1+2p4+p7)-(p3+2p6+p9), dy = (p1+2p2+p3)-(p7+2p8+p9), both 12-bit signed; mag = |dx|+|dy|, 11-bit unsigned (max 2040).
- Border mask: if x<2 or y<2, mag forced to 0.
- mode 0: out channel = (mag > threshold) ? 255 : 0 (strict compare). mode 1: out channel = min(mag, 255).
- Output image is thus the edge map shifted by (+1,+1), with rows 0-1 and columns 0-1 zero.

## Timing
- Latency: out_valid exactly 3 cycles after the cycle in_valid was high; 1:1, order preserved, gaps preserved.
- Pipeline: S1 register gray, x, y, sof, threshold, mode; S2 line-buffer read/write and window shift; S3 kernel, mask, mode, output register.
- Back-to-back in_valid sustains 1 pixel/cycle.
- Reset: out_valid, out_sof, frame_err, out_data = 0; x = y = 0; window and pipeline cleared. Line-buffer contents undefined and never observable (masking covers rows 0-1).
- Reset mid-frame: in-flight pixels discarded (no out_valid for them); next accepted pixel is (0,0).
- in_sof at (0,0) after a full frame: no frame_err.
- frame_err is aligned with the offending pixel's out_valid (same 3-cycle delay).

## Structure
- Shared package global.vh: `PIXEL_SIZE`, `WORD_SIZE` (8), new `GRAD_SIZE` (11).
- Sub-module sobel_kernel: combinational 3x3 x 8-bit to 11-bit magnitude, signed internals at 12 bits.
- Line buffers are inferred memories inside sobel_edge_stream; no reset on them.

## Test plan
- WIDTH=8, HEIGHT=4, mode 0, threshold 150; columns 0-3 RGB 0, columns 4-7 RGB 0xFFFFFF (I=234) -> output 0xFFFFFF at input x=4,5 for y=2,3; 0 elsewhere; out_valid 3 cycles after each in_valid.
- Same image, threshold 936 -> all 0; threshold 935 -> edge columns 0xFFFFFF (mag 936).
- Same image, mode 1 -> edge columns 0xFFFFFF (saturated 255), others 0; uniform 0x808080 image -> all 0.
- Same image with random in_valid gaps (~50% duty) -> identical output sequence to gapless run; out_valid count = 32.
- in_sof asserted at pixel (5,1) -> frame_err pulse aligned with that pixel's output, that pixel treated as (0,0), next two output rows all 0.
- reset asserted 1 cycle mid-frame with 3 pixels in flight -> no out_valid for them; all outputs 0 next cycle; following frame output correct.
